// File: rtl/serial_byte_assembler_pkg.sv
// ---------------------------------------------------------------------------
// serial_byte_assembler_pkg
// Shared constants and helpers for the serial byte assembler.
//   DEF_WIDTH : default number of data bits per word (8, matches the decoder)
//   cnt_w()   : bit counter width. It is sized for WIDTH+1 so that one
//               counter width covers both the plain frame and the frame
//               that carries a trailing parity bit.
// Optional feature macro used by the design: PARITY_CHECK_EN
// ---------------------------------------------------------------------------
package serial_byte_assembler_pkg;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/ser_shift_collector.sv
// ---------------------------------------------------------------------------
// ser_shift_collector
// Shifts a bit-serial stream into a WIDTH-bit register. It counts the bits
// in the current frame and accumulates even parity over the data bits.
// When the last bit of a frame is sampled, frame_done pulses for that one
// cycle. frame_data then carries the completed word, including a final data
// bit that is being sampled on that same edge.
//
// Parameters:
//   WIDTH     : data bits per word (2..16)
//   MSB_FIRST : 1 -> the first bit ends up in frame_data[WIDTH-1]
//               0 -> the first bit ends up in frame_data[0]
//   PARITY_EN : 1 -> the frame has one extra trailing even-parity bit
//   CW        : counter width
//
// Ports:
//   clk        : rising-edge clock
//   clear      : asynchronous active-low reset
//   ser_in     : serial data bit
//   ser_valid  : ser_in is sampled on this edge
//   frame_done : one-cycle pulse on the edge that completes a frame
//   frame_data : completed word, valid while frame_done=1
//   parity_ok  : parity check result, valid while frame_done=1 and PARITY_EN
//   count      : number of bits collected in the current frame
// ---------------------------------------------------------------------------
module ser_shift_collector
    import serial_byte_assembler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0,
    parameter int CW        = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             frame_done,
    output logic [WIDTH-1:0] frame_data,
    output logic             parity_ok,
    output logic [CW-1:0]    count
);

    localparam int            FRAME_LEN = PARITY_EN ? WIDTH + 1 : WIDTH;
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count_q, count_d;
    logic             parity_q, parity_d;

    // The register contents after ser_in has been shifted in. The shift
    // direction decides which end of the word the first bit lands on.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], ser_in};
        end else begin
            shifted = {ser_in, shift_q[WIDTH-1:1]};
        end
    end

    // Next-state logic. Only data bits enter the shift register and the
    // parity accumulator. A trailing parity bit is compared but never stored.
    // The counter and parity accumulator restart on the completion edge.
    always_comb begin
        shift_d    = shift_q;
        count_d    = count_q;
        parity_d   = parity_q;
        frame_done = 1'b0;
        if (ser_valid) begin
            if (count_q < DATA_BITS) begin
                shift_d  = shifted;
                parity_d = parity_q ^ ser_in;
            end
            if (count_q == LAST_IDX) begin
                frame_done = 1'b1;
                count_d    = '0;
                parity_d   = 1'b0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // In a plain frame the final data bit arrives on the completion edge, so
    // the word is taken from the freshly shifted value. In a parity frame all
    // data bits are already in the register.
    assign frame_data = PARITY_EN ? shift_q : shifted;
    assign parity_ok  = ~(parity_q ^ ser_in);
    assign count      = count_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            shift_q  <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            count_q  <= count_d;
            parity_q <= parity_d;
        end
    end

endmodule

// File: rtl/serial_byte_assembler.sv
// ---------------------------------------------------------------------------
// serial_byte_assembler
// Collects a bit-serial stream into WIDTH-bit words. Each word is presented
// to the downstream decoder through a one-entry holding register with a
// valid/ready handshake. A word that completes while the holding register
// is still full and not being accepted is dropped, and the sticky overrun
// flag is set.
//
// Optional feature macro: PARITY_CHECK_EN
//   When it is defined, each frame carries a trailing even-parity bit.
//   Frames that fail the check are discarded and set the sticky parity_err
//   output.
//
// Parameters:
//   WIDTH     : data bits per word (2..16)
//   MSB_FIRST : 1 -> the first received bit lands in word_out[WIDTH-1]
//               0 -> the first received bit lands in word_out[0]
//
// Ports:
//   clk         : rising-edge clock
//   clear       : asynchronous active-low reset
//   ser_in      : serial data bit
//   ser_valid   : ser_in is sampled on this edge
//   word_out    : assembled word (decoder input bus)
//   word_valid  : word_out holds an unconsumed word
//   word_ready  : downstream accepts word_out on an edge where word_valid=1
//   overrun     : sticky, a completed word was dropped
//   overrun_clr : synchronous clear for overrun (and for parity_err)
//   bit_count   : bits collected in the current frame
//   parity_err  : sticky parity mismatch flag (PARITY_CHECK_EN only)
// ---------------------------------------------------------------------------
module serial_byte_assembler
    import serial_byte_assembler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       ser_in,
    input  logic                       ser_valid,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
`ifdef PARITY_CHECK_EN
    ,
    output logic                       parity_err
`endif
);

    localparam int CW = cnt_w(WIDTH);
    localparam int BW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             frame_done;
    logic [WIDTH-1:0] frame_data;
    logic             parity_ok;
    logic [CW-1:0]    count;
    logic             frame_ok;
    logic             set_ovr;

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    ser_shift_collector #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST != 0),
        .PARITY_EN (PAR_EN),
        .CW        (CW)
    ) u_collector (
        .clk        (clk),
        .clear      (clear),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .frame_done (frame_done),
        .frame_data (frame_data),
        .parity_ok  (parity_ok),
        .count      (count)
    );

    // A completed frame may only reach the holding register if it passes
    // parity. Without the parity feature every completed frame qualifies.
    assign frame_ok = frame_done & (~PAR_EN | parity_ok);

    // Holding register and handshake. An acceptance frees the slot, and a
    // word that completes on that same edge refills it with no bubble.
    // A completing word with nowhere to go is dropped and flags overrun.
    // A set of overrun on the same edge as overrun_clr takes priority.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        set_ovr = 1'b0;
        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
        if (frame_ok) begin
            if (!valid_q || word_ready) begin
                word_d  = frame_data;
                valid_d = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end
        overrun_d = set_ovr | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;

    // Sticky parity error. A new mismatch wins over a simultaneous clear.
    always_comb begin
        perr_d = (frame_done & ~parity_ok) | (perr_q & ~overrun_clr);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign overrun    = overrun_q;
    assign bit_count  = count[BW-1:0];

endmodule

// File: tb/tb_serial_byte_assembler.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_assembler
// Directed bench for serial_byte_assembler. Two instances share all inputs.
// dutMsb uses MSB_FIRST=1 and dutLsb uses MSB_FIRST=0. Inputs change 1 ns
// after each rising edge, and outputs are checked at that same point.
// When PARITY_CHECK_EN is defined, a correct parity bit is appended to every
// frame and an extra parity section runs at the end.
// ---------------------------------------------------------------------------
module tb_serial_byte_assembler;

`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       clear;
    logic       serIn;
    logic       serValid;
    logic       wordReady;
    logic       overrunClr;

    logic [7:0] wordOutM, wordOutL;
    logic       wordValidM, wordValidL;
    logic       overrunM, overrunL;
    logic [3:0] bitCountM, bitCountL;
`ifdef PARITY_CHECK_EN
    logic       parityErrM, parityErrL;
`endif

    int errors = 0;
    int checks = 0;

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1)) dutMsb (
        .clk         (clk),
        .clear       (clear),
        .ser_in      (serIn),
        .ser_valid   (serValid),
        .word_out    (wordOutM),
        .word_valid  (wordValidM),
        .word_ready  (wordReady),
        .overrun     (overrunM),
        .overrun_clr (overrunClr),
        .bit_count   (bitCountM)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err  (parityErrM)
`endif
    );

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(0)) dutLsb (
        .clk         (clk),
        .clear       (clear),
        .ser_in      (serIn),
        .ser_valid   (serValid),
        .word_out    (wordOutL),
        .word_valid  (wordValidL),
        .word_ready  (wordReady),
        .overrun     (overrunL),
        .overrun_clr (overrunClr),
        .bit_count   (bitCountL)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err  (parityErrL)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    // One comparison: count it, and report a failure with tag and values
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle 1 ns past the next rising edge
    task automatic applyStimulus(input logic bitVal, input logic valid, input logic ready);
        serIn     = bitVal;
        serValid  = valid;
        wordReady = ready;
        @(posedge clk);
        #1;
    endtask

    // Send one frame of 8 data bits, first bit = bits[7], plus a correct
    // even-parity bit when parity is enabled. word_ready is driven only on
    // the completion edge. If gapAt >= 0, two ser_valid=0 cycles are inserted
    // after data bit gapAt, and the bench checks that bit_count holds.
    task automatic sendBits(input logic [7:0] bits, input logic readyLast, input int gapAt);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(bits[7-i], 1'b1, readyLast & (i == 7) & ~PAR);
            if (i == gapAt) begin
                applyStimulus(1'b1, 1'b0, 1'b0);
                applyStimulus(1'b1, 1'b0, 1'b0);
                checkOutput("gapHoldCount", 32'(bitCountM), 32'(i + 1));
            end
        end
        if (PAR) begin
            applyStimulus(^bits, 1'b1, readyLast);
        end
        serValid  = 1'b0;
        wordReady = 1'b0;
    endtask

    initial begin
        clear      = 1'b0;
        serIn      = 1'b0;
        serValid   = 1'b0;
        wordReady  = 1'b0;
        overrunClr = 1'b0;
        #2;
        checkOutput("resetWord",     32'(wordOutM),   32'h0);
        checkOutput("resetValid",    32'(wordValidM), 32'h0);
        checkOutput("resetOverrun",  32'(overrunM),   32'h0);
        checkOutput("resetBitCount", 32'(bitCountM),  32'h0);
        clear = 1'b1;

        // Reset in the middle of a frame
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("partialCount", 32'(bitCountM), 32'h3);
        serValid = 1'b0;
        clear    = 1'b0;
        #1;
        checkOutput("midResetCountM", 32'(bitCountM), 32'h0);
        checkOutput("midResetCountL", 32'(bitCountL), 32'h0);
        checkOutput("midResetValid",  32'(wordValidM), 32'h0);
        clear = 1'b1;
        #1;

        // 0xA5, stream 1,0,1,0,0,1,0,1, a clean word after the reset
        sendBits(8'hA5, 1'b0, 6);
        checkOutput("a5WordMsb",  32'(wordOutM),   32'hA5);
        checkOutput("a5WordLsb",  32'(wordOutL),   32'hA5);
        checkOutput("a5ValidMsb", 32'(wordValidM), 32'h1);
        checkOutput("a5BitCount", 32'(bitCountM),  32'h0);
        checkOutput("a5Overrun",  32'(overrunM),   32'h0);

        // Stream 1,0,0,0,0,0,0,0 accepted back-to-back on the completion edge
        sendBits(8'h80, 1'b1, -1);
        checkOutput("b2bWordLsb",  32'(wordOutL),   32'h01);
        checkOutput("b2bWordMsb",  32'(wordOutM),   32'h80);
        checkOutput("b2bValid",    32'(wordValidM), 32'h1);
        checkOutput("b2bOverrun",  32'(overrunM),   32'h0);

        // Plain acceptance: valid drops, the word is retained
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("acceptValid", 32'(wordValidM), 32'h0);
        checkOutput("acceptWord",  32'(wordOutM),   32'h80);
        // word_ready while empty has no effect
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idleReadyValid", 32'(wordValidM), 32'h0);

        // Overrun: 0x3C then 0xC3 with word_ready held low
        sendBits(8'h3C, 1'b0, 3);
        checkOutput("w3cWord",  32'(wordOutM),   32'h3C);
        checkOutput("w3cValid", 32'(wordValidM), 32'h1);
        sendBits(8'hC3, 1'b0, -1);
        checkOutput("ovrWord",    32'(wordOutM),   32'h3C);
        checkOutput("ovrFlag",    32'(overrunM),   32'h1);
        checkOutput("ovrValid",   32'(wordValidM), 32'h1);

        overrunClr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        overrunClr = 1'b0;
        checkOutput("ovrCleared",   32'(overrunM), 32'h0);
        checkOutput("ovrClrKeepWd", 32'(wordOutM), 32'h3C);

        // Back-to-back replacement of 0x3C by 0xC3
        sendBits(8'hC3, 1'b1, -1);
        checkOutput("c3Word",    32'(wordOutM),   32'hC3);
        checkOutput("c3Valid",   32'(wordValidM), 32'h1);
        checkOutput("c3Overrun", 32'(overrunM),   32'h0);

        // Overrun set on the same edge as overrun_clr: the set wins
        overrunClr = 1'b1;
        sendBits(8'h5A, 1'b0, -1);
        overrunClr = 1'b0;
        checkOutput("setWinsOvr",  32'(overrunM), 32'h1);
        checkOutput("setWinsWord", 32'(wordOutM), 32'hC3);

        // Asynchronous reset clears everything without a clock edge
        clear = 1'b0;
        #1;
        checkOutput("asyncWord",    32'(wordOutM),   32'h0);
        checkOutput("asyncValid",   32'(wordValidM), 32'h0);
        checkOutput("asyncOverrun", 32'(overrunM),   32'h0);
        clear = 1'b1;
        #1;

`ifdef PARITY_CHECK_EN
        // Good parity (0xA5 has four ones, so the parity bit is 0)
        sendBits(8'hA5, 1'b0, 7);
        checkOutput("parGoodWord",  32'(wordOutM),   32'hA5);
        checkOutput("parGoodValid", 32'(wordValidM), 32'h1);
        checkOutput("parGoodErr",   32'(parityErrM), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("parAccept", 32'(wordValidM), 32'h0);
        // Bad parity bit: the word is dropped and parity_err is set
        begin
            logic [7:0] pat;
            pat = 8'hA5;
            for (int i = 0; i < 8; i++) begin
                applyStimulus(pat[7-i], 1'b1, 1'b0);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        serValid = 1'b0;
        checkOutput("parBadErr",     32'(parityErrM), 32'h1);
        checkOutput("parBadValid",   32'(wordValidM), 32'h0);
        checkOutput("parBadOverrun", 32'(overrunM),   32'h0);
        overrunClr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        overrunClr = 1'b0;
        checkOutput("parErrCleared", 32'(parityErrM), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
